regfile_wb_arbiter: RTL

- Shares the single write port of the 8 x 16-bit register file between two writeback requesters: req0 (ALU) and req1 (memory load).
- Each requester pushes {reg, data} through a valid/ready handshake into its own FIFO.
- A round-robin scheduler drains the FIFOs, issuing at most one registered write per cycle.
- Drives the register file's write, wreg and wd inputs, and exports a pending-write mask that decode uses for hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two requesters share the register file's single write port
// through per-requester FIFOs drained by a round-robin scheduler.
`timescale 1ns/1ps

module regfile_wb_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [2:0]       push_reg,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [2:0]       head_reg,
    output logic [WIDTH-1:0] head_data,
    output logic [7:0]       pend_mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [2:0]       reg_mem_q  [DEPTH];
    logic [2:0]       reg_mem_d  [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic [WIDTH-1:0] data_mem_d [DEPTH];
    logic             full;
    logic             push;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even in a cycle where it is also popped.
    assign full       = (count_q == (PW+1)'(DEPTH));
    assign push_ready = !rst && !full;
    assign push       = push_valid && push_ready;
    assign head_valid = (count_q != '0);
    assign head_reg   = reg_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            reg_mem_d[wr_ptr_q]  = push_reg;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q) begin
                pend_mask[reg_mem_q[i]] = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        reg_mem_q  <= reg_mem_d;
        data_mem_q <= data_mem_d;
    end
endmodule

module regfile_wb_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_reg,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_reg,
    input  logic [WIDTH-1:0] req1_data,
    output logic             write,
    output logic [2:0]       wreg,
    output logic [WIDTH-1:0] wd,
    output logic [7:0]       pending
);
    logic             head0_valid, head1_valid;
    logic [2:0]       head0_reg, head1_reg;
    logic [WIDTH-1:0] head0_data, head1_data;
    logic [7:0]       pend0, pend1;
    logic             pop0, pop1;
    logic             grant_valid, grant_sel;

    logic             write_q, write_d;
    logic [2:0]       wreg_q, wreg_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic             rr_q, rr_d;

    regfile_wb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .push_valid (req0_valid),
        .push_ready (req0_ready),
        .push_reg   (req0_reg),
        .push_data  (req0_data),
        .pop        (pop0),
        .head_valid (head0_valid),
        .head_reg   (head0_reg),
        .head_data  (head0_data),
        .pend_mask  (pend0)
    );

    regfile_wb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .push_valid (req1_valid),
        .push_ready (req1_ready),
        .push_reg   (req1_reg),
        .push_data  (req1_data),
        .pop        (pop1),
        .head_valid (head1_valid),
        .head_reg   (head1_reg),
        .head_data  (head1_data),
        .pend_mask  (pend1)
    );

    // rr_q names the favoured requester when both heads compete; any grant
    // hands priority to the other side.
    always_comb begin
        grant_valid = head0_valid || head1_valid;
        grant_sel   = (head0_valid && head1_valid) ? rr_q : head1_valid;
        pop0        = grant_valid && !grant_sel;
        pop1        = grant_valid && grant_sel;
        write_d     = grant_valid;
        wreg_d      = wreg_q;
        wd_d        = wd_q;
        rr_d        = rr_q;
        if (grant_valid) begin
            wreg_d = grant_sel ? head1_reg  : head0_reg;
            wd_d   = grant_sel ? head1_data : head0_data;
            rr_d   = !grant_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            wreg_q  <= '0;
            wd_q    <= '0;
            rr_q    <= 1'b0;
        end else begin
            write_q <= write_d;
            wreg_q  <= wreg_d;
            wd_q    <= wd_d;
            rr_q    <= rr_d;
        end
    end

    assign write = write_q;
    assign wreg  = wreg_q;
    assign wd    = wd_q;

    always_comb begin
        pending = pend0 | pend1;
        if (write_q) begin
            pending[wreg_q] = 1'b1;
        end
    end
endmodule
